torus_seed_ctrl: RTL and testbench

- Drives the torus cell array's serial load chain and its generation stepping.
- Shifts a W*H-bit seed stream into the array on seed/seed_ena from one of three sources: on-chip LFSR, all-zero clear, or recirculation of torus_last.
- During recirculation, publishes the shifted-out grid as a serial scan stream for display/readout logic.
- After any load, issues single-cycle life_step pulses at a programmable rate.

---
 rtl/torus_seed_ctrl.sv | 178 +++++++++++++++++
 tb/tb_torus_seed_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/torus_seed_ctrl.sv
// -----------------------------------------------------------------------------
// torus_seed_ctrl
//   Loads the torus cell array through its serial load chain and paces the
//   generation stepping afterwards.
//
//   A load shifts W*H bits into the array on seed/seed_ena. Each load takes
//   its bits from one of three sources: the on-chip LFSR, all zeros, or
//   torus_last fed back into the chain. Feeding torus_last back leaves the
//   array content unchanged. During that recirculation the bits leaving the
//   chain are also published on scan_bit/scan_valid. After any load, single
//   cycle life_step pulses are issued every STEP_DIV enabled cycles.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   cmd_valid       load command request
//   cmd_ready       command can be accepted this cycle (low while loading)
//   cmd_mode        0 = LFSR random, 1/3 = clear, 2 = recirculate
//   run_en          enables generation stepping once running
//   torus_last      last cell of the array load chain
//   seed            serial seed bit (0 when not shifting)
//   seed_ena        array shift enable
//   life_step       generation step pulse
//   busy            high while a load is shifting
//   scan_bit        bit leaving the array (valid with scan_valid)
//   scan_valid      scan_bit qualifier, only during recirculation
//   gen_count       generations stepped since last random/clear load
// -----------------------------------------------------------------------------
module torus_seed_ctrl #(
    parameter int unsigned TORUS_WIDTH  = 32,
    parameter int unsigned TORUS_HEIGHT = 32,
    parameter int unsigned STEP_DIV     = 1000000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_mode,
    input  logic        run_en,
    input  logic        torus_last,
    output logic        seed,
    output logic        seed_ena,
    output logic        life_step,
    output logic        busy,
    output logic        scan_bit,
    output logic        scan_valid,
    output logic [15:0] gen_count
);

    localparam int unsigned CELLS   = TORUS_WIDTH * TORUS_HEIGHT;
    localparam int unsigned CNT_W   = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned DIV_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned GEN_W   = 16;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELLS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    localparam logic [1:0] MODE_RANDOM = 2'd0;
    localparam logic [1:0] MODE_RECIRC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [1:0]         mode_q,      mode_d;
    logic [LFSR_W-1:0]  lfsr_q,      lfsr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic [GEN_W-1:0]   gen_q,       gen_d;
    logic               seed_ena_q,  seed_ena_d;
    logic               life_step_q, life_step_d;

    logic               lfsr_fb;
    logic               cmd_accept;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    assign cmd_ready  = (state_q != ST_LOAD);
    assign cmd_accept = cmd_valid & cmd_ready;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        gen_d       = gen_q;
        seed_ena_d  = seed_ena_q;
        life_step_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // LFSR advances only on cycles that actually shift a random bit
                if (mode_q == MODE_RANDOM) begin
                    lfsr_d = {lfsr_fb, lfsr_q[LFSR_W-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    div_d      = '0;
                    seed_ena_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                // A new command wins over a step falling on the same cycle
                if (cmd_accept) begin
                    state_d    = ST_LOAD;
                    mode_d     = cmd_mode;
                    cnt_d      = '0;
                    seed_ena_d = 1'b1;
                    if (cmd_mode != MODE_RECIRC) begin
                        gen_d = '0;
                    end
                end else if ((state_q == ST_RUN) && run_en) begin
                    if (div_q == DIV_LAST) begin
                        div_d       = '0;
                        life_step_d = 1'b1;
                        gen_d       = gen_q + GEN_W'(1);
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_RANDOM;
            lfsr_q      <= LFSR_SEED;
            cnt_q       <= '0;
            div_q       <= '0;
            gen_q       <= '0;
            seed_ena_q  <= 1'b0;
            life_step_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            gen_q       <= gen_d;
            seed_ena_q  <= seed_ena_d;
            life_step_q <= life_step_d;
        end
    end

    // Serial seed source; forced low outside a shift so the array sees clean zeros
    always_comb begin
        seed = 1'b0;
        if (seed_ena_q) begin
            case (mode_q)
                MODE_RANDOM: seed = lfsr_q[0];
                MODE_RECIRC: seed = torus_last;
                default:     seed = 1'b0;
            endcase
        end
    end

    assign seed_ena   = seed_ena_q;
    assign busy       = seed_ena_q;
    assign life_step  = life_step_q;
    assign gen_count  = gen_q;
    assign scan_bit   = torus_last;
    assign scan_valid = seed_ena_q & (mode_q == MODE_RECIRC);

endmodule

// File: tb/tb_torus_seed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_torus_seed_ctrl
//   Self-checking bench for torus_seed_ctrl with a 32x32 array model on the
//   load chain and a transaction-level reference model of loads and stepping.
// -----------------------------------------------------------------------------
module tb_torus_seed_ctrl;

    localparam int unsigned TW = 32;
    localparam int unsigned TH = 32;
    localparam int unsigned N  = TW * TH;
    localparam int unsigned SD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic        run_en;
    logic        torus_last;
    logic        seed;
    logic        seed_ena;
    logic        life_step;
    logic        busy;
    logic        scan_bit;
    logic        scan_valid;
    logic [15:0] gen_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    torus_seed_ctrl #(
        .TORUS_WIDTH (TW),
        .TORUS_HEIGHT(TH),
        .STEP_DIV    (SD),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .run_en    (run_en),
        .torus_last(torus_last),
        .seed      (seed),
        .seed_ena  (seed_ena),
        .life_step (life_step),
        .busy      (busy),
        .scan_bit  (scan_bit),
        .scan_valid(scan_valid),
        .gen_count (gen_count)
    );

    // Array model: seed enters cell 0, cells move toward N-1, torus_last = cell N-1
    logic [N-1:0] cells = '0;
    logic         preset_req;
    logic [N-1:0] preset_val;

    always @(posedge clk) begin
        if (preset_req)    cells <= preset_val;
        else if (seed_ena) cells <= {cells[N-2:0], seed};
    end
    assign torus_last = cells[N-1];

    // Reference model, state as seen after the most recent clock edge
    logic [15:0] m_lfsr;
    logic [1:0]  m_mode;
    bit          m_loading, m_run, m_step;
    int          m_left, m_phase, m_gen;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        int unsigned v, fb;
        v  = 32'(x);
        fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 32'd1;
        return 16'((v >> 1) | (fb << 15));
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_mode = 2'd0;
        m_loading = 1'b0; m_run = 1'b0; m_step = 1'b0;
        m_left = 0; m_phase = 0; m_gen = 0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] md, input bit ren);
        m_step = 1'b0;
        if (m_loading) begin
            if (m_mode == 2'd0) m_lfsr = lfsr_next(m_lfsr);
            m_left--;
            if (m_left == 0) begin
                m_loading = 1'b0; m_run = 1'b1; m_phase = 0;
            end
        end else if (v) begin
            m_loading = 1'b1; m_left = N; m_mode = md;
            if (md != 2'd2) m_gen = 0;
        end else if (m_run && ren) begin
            m_phase++;
            if (m_phase == SD) begin
                m_phase = 0; m_step = 1'b1; m_gen = (m_gen + 1) % 65536;
            end
        end
    endtask

    function automatic logic exp_seed();
        if (!m_loading)     return 1'b0;
        if (m_mode == 2'd0) return m_lfsr[0];
        if (m_mode == 2'd2) return torus_last;
        return 1'b0;
    endfunction

    function automatic int first_one(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i] !== 1'b0) return i;
        return -1;
    endfunction

    // One clock: drive at negedge, let the edge happen, return at next negedge
    task automatic cycle(input bit v, input logic [1:0] md, input bit ren);
        cmd_valid = v; cmd_mode = md; run_en = ren;
        model_edge(v, md, ren);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; run_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Captured per-shift observations of one load (index = shift number)
    logic [N-1:0] cap_ena, cap_seed, cap_exp, cap_busy, cap_rdy, cap_sv, cap_sb, cap_step;

    task automatic load_capture(input logic [1:0] md, input bit ren);
        cycle(1'b1, md, ren);
        for (int k = 0; k < N; k++) begin
            cap_ena[k]  = seed_ena;  cap_seed[k] = seed;       cap_exp[k]  = exp_seed();
            cap_busy[k] = busy;      cap_rdy[k]  = cmd_ready;  cap_sv[k]   = scan_valid;
            cap_sb[k]   = scan_bit;  cap_step[k] = life_step;
            // a command mid-load must be dropped
            if (k == N / 2) cycle(1'b1, 2'd1, ren);
            else            cycle(1'b0, 2'd0, ren);
        end
    endtask

    task automatic test_reset();
        int pulses = 0;
        apply_reset();
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (seed_ena !== 1'b0)   begin errors++; $display("FAIL reset_seed_ena: got %b want 0", seed_ena); end
        checks++; if (life_step !== 1'b0)  begin errors++; $display("FAIL reset_life_step: got %b want 0", life_step); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid: got %b want 0", scan_valid); end
        checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen_count: got %0d want 0", gen_count); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 2'd0, 1'b1);
            if (life_step !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL idle_no_step: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_random_load();
        logic [N-1:0] exp_cells;
        load_capture(2'd0, 1'b1);
        checks++; if (cap_ena !== '1) begin errors++; $display("FAIL rand_seed_ena: low at shift %0d want high for %0d shifts", first_one(~cap_ena), N); end
        checks++; if (cap_busy !== '1) begin errors++; $display("FAIL rand_busy: low at shift %0d want high", first_one(~cap_busy)); end
        checks++; if (cap_rdy !== '0) begin errors++; $display("FAIL rand_cmd_ready: high at shift %0d want low", first_one(cap_rdy)); end
        checks++; if (cap_step !== '0) begin errors++; $display("FAIL rand_no_step: life_step at shift %0d want none", first_one(cap_step)); end
        checks++; if (cap_sv !== '0) begin errors++; $display("FAIL rand_scan_valid: high at shift %0d want low", first_one(cap_sv)); end
        checks++; if (cap_seed !== cap_exp) begin errors++; $display("FAIL rand_seed_seq: first diff at shift %0d got %b want %b", first_one(cap_seed ^ cap_exp), cap_seed[first_one(cap_seed ^ cap_exp)], cap_exp[first_one(cap_seed ^ cap_exp)]); end
        checks++; if (cap_seed[15:0] !== 16'hACE1) begin errors++; $display("FAIL rand_first16: got %h want ace1", cap_seed[15:0]); end
        checks++; if (seed_ena !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rand_end: seed_ena=%b cmd_ready=%b want 0/1", seed_ena, cmd_ready); end
        checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL rand_gen: got %0d want 0", gen_count); end
        for (int k = 0; k < N; k++) exp_cells[N-1-k] = cap_exp[k];
        checks++; if (cells !== exp_cells) begin errors++; $display("FAIL rand_cells: first wrong cell %0d", first_one(cells ^ exp_cells)); end
    endtask

    task automatic test_clear();
        int bad = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 2'd0, 1'b1);
            if (life_step !== m_step) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pre_clear_step: %0d cycles wrong want 0", bad); end
        checks++; if (gen_count !== 16'd2) begin errors++; $display("FAIL pre_clear_gen: got %0d want 2", gen_count); end
        load_capture(2'd1, 1'b0);
        checks++; if (cap_ena !== '1) begin errors++; $display("FAIL clear_seed_ena: low at shift %0d", first_one(~cap_ena)); end
        checks++; if (cap_seed !== '0) begin errors++; $display("FAIL clear_seed: one at shift %0d want 0", first_one(cap_seed)); end
        checks++; if (cells !== '0) begin errors++; $display("FAIL clear_cells: cell %0d nonzero want 0", first_one(cells)); end
        checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL clear_gen: got %0d want 0", gen_count); end
    endtask

    task automatic test_step_timing();
        int pulse_at[$];
        int bad = 0;
        int pos_bad = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 2'd0, 1'b1);
            if (life_step !== m_step) bad++;
            if (life_step === 1'b1) pulse_at.push_back(i);
        end
        checks++; if (pulse_at.size() != 5) begin errors++; $display("FAIL step_count: got %0d pulses want 5", pulse_at.size()); end
        foreach (pulse_at[j]) if (pulse_at[j] != 4 * (j + 1)) pos_bad++;
        checks++; if (pos_bad != 0) begin errors++; $display("FAIL step_spacing: %0d pulses off the 4-cycle grid want 0", pos_bad); end
        checks++; if (gen_count !== 16'd5) begin errors++; $display("FAIL step_gen5: got %0d want 5", gen_count); end
        pulse_at.delete();
        for (int i = 21; i <= 31; i++) begin
            cycle(1'b0, 2'd0, (i >= 23 && i <= 29) ? 1'b0 : 1'b1);
            if (life_step !== m_step) bad++;
            if (life_step === 1'b1) pulse_at.push_back(i);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL step_model: %0d cycles wrong want 0", bad); end
        checks++; if (pulse_at.size() != 1 || pulse_at[0] - 20 != 11) begin errors++; $display("FAIL step_pause_gap: got %0d pulses, gap %0d want 1 pulse gap 11", pulse_at.size(), (pulse_at.size() > 0) ? pulse_at[0] - 20 : -1); end
        checks++; if (gen_count !== 16'd6) begin errors++; $display("FAIL step_gen6: got %0d want 6", gen_count); end
    endtask

    task automatic test_recirc();
        logic [N-1:0] pattern;
        logic [N-1:0] exp_scan;
        for (int i = 0; i < N; i++) pattern[i] = 1'((i & 1) ^ ((i >> 5) & 1));
        preset_val = pattern; preset_req = 1'b1;
        cycle(1'b0, 2'd0, 1'b0);
        preset_req = 1'b0;
        load_capture(2'd2, 1'b0);
        for (int k = 0; k < N; k++) exp_scan[k] = pattern[N-1-k];
        checks++; if (cap_sv !== '1) begin errors++; $display("FAIL recirc_scan_valid: low at shift %0d want high", first_one(~cap_sv)); end
        checks++; if (cap_sb !== exp_scan) begin errors++; $display("FAIL recirc_scan_order: first diff at shift %0d", first_one(cap_sb ^ exp_scan)); end
        checks++; if (cap_seed !== exp_scan) begin errors++; $display("FAIL recirc_seed: first diff at shift %0d", first_one(cap_seed ^ exp_scan)); end
        checks++; if (cells !== pattern) begin errors++; $display("FAIL recirc_cells: first changed cell %0d", first_one(cells ^ pattern)); end
        checks++; if (gen_count !== 16'd6) begin errors++; $display("FAIL recirc_gen: got %0d want 6", gen_count); end
    endtask

    task automatic test_cmd_on_terminal();
        int stray = 0;
        logic [15:0] g0;
        for (int i = 0; i < SD - 1; i++) begin
            cycle(1'b0, 2'd0, 1'b1);
            if (life_step !== 1'b0) stray++;
        end
        g0 = 16'(m_gen);
        cycle(1'b1, 2'd2, 1'b1);
        checks++; if (stray != 0 || life_step !== 1'b0) begin errors++; $display("FAIL term_no_step: life_step=%b stray=%0d want 0/0", life_step, stray); end
        checks++; if (seed_ena !== 1'b1) begin errors++; $display("FAIL term_seed_ena: got %b want 1", seed_ena); end
        checks++; if (gen_count !== g0) begin errors++; $display("FAIL term_gen: got %0d want %0d", gen_count, g0); end
        for (int i = 0; i < N; i++) cycle(1'b0, 2'd0, 1'b0);
        checks++; if (seed_ena !== 1'b0) begin errors++; $display("FAIL term_load_len: seed_ena=%b after %0d shifts want 0", seed_ena, N); end
    endtask

    task automatic test_random_run();
        int bad_ena = 0, bad_step = 0, bad_gen = 0, bad_seed = 0;
        int bad_rdy = 0, bad_scan = 0, overlap = 0;
        bit v, ren;
        logic [1:0] md;
        for (int i = 0; i < 10000; i++) begin
            v   = ($urandom_range(0, 299) == 0);
            md  = 2'($urandom_range(0, 3));
            ren = ($urandom_range(0, 3) != 0);
            cycle(v, md, ren);
            if (seed_ena !== m_loading)          bad_ena++;
            if (busy !== m_loading)              bad_ena++;
            if (life_step !== m_step)            bad_step++;
            if (gen_count !== 16'(m_gen))        bad_gen++;
            if (seed !== exp_seed())             bad_seed++;
            if (cmd_ready !== !m_loading)        bad_rdy++;
            if (scan_valid !== (m_loading && m_mode == 2'd2)) bad_scan++;
            if (scan_valid === 1'b1 && scan_bit !== torus_last) bad_scan++;
            if (seed_ena === 1'b1 && life_step === 1'b1) overlap++;
        end
        checks++; if (overlap != 0)  begin errors++; $display("FAIL rr_overlap: %0d cycles with seed_ena and life_step want 0", overlap); end
        checks++; if (bad_ena != 0)  begin errors++; $display("FAIL rr_seed_ena: %0d wrong want 0", bad_ena); end
        checks++; if (bad_step != 0) begin errors++; $display("FAIL rr_life_step: %0d wrong want 0", bad_step); end
        checks++; if (bad_gen != 0)  begin errors++; $display("FAIL rr_gen_count: %0d wrong want 0", bad_gen); end
        checks++; if (bad_seed != 0) begin errors++; $display("FAIL rr_seed: %0d wrong want 0", bad_seed); end
        checks++; if (bad_rdy != 0)  begin errors++; $display("FAIL rr_cmd_ready: %0d wrong want 0", bad_rdy); end
        checks++; if (bad_scan != 0) begin errors++; $display("FAIL rr_scan: %0d wrong want 0", bad_scan); end
    endtask

    task automatic test_reset_mid_load();
        int pulses = 0;
        for (int i = 0; i < N + 2 && m_loading; i++) cycle(1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3 * SD; i++) cycle(1'b0, 2'd0, 1'b1);
        cycle(1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 500; i++) cycle(1'b0, 2'd0, 1'b0);
        checks++; if (seed_ena !== 1'b1) begin errors++; $display("FAIL mid_load_active: seed_ena=%b at shift 500 want 1", seed_ena); end
        apply_reset();
        checks++; if (seed_ena !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_seed_ena: seed_ena=%b busy=%b want 0/0", seed_ena, busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL abort_gen: got %0d want 0", gen_count); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 2'd0, 1'b1);
            if (life_step !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_idle: got %0d pulses want 0", pulses); end
        load_capture(2'd0, 1'b0);
        checks++; if (cap_seed[15:0] !== 16'hACE1) begin errors++; $display("FAIL abort_lfsr_first16: got %h want ace1", cap_seed[15:0]); end
        checks++; if (cap_seed !== cap_exp) begin errors++; $display("FAIL abort_lfsr_seq: first diff at shift %0d", first_one(cap_seed ^ cap_exp)); end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; run_en = 1'b0;
        preset_req = 1'b0; preset_val = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_random_load();
        test_clear();
        test_step_timing();
        test_recirc();
        test_cmd_on_terminal();
        test_random_run();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
